// File: rtl/frontend_source_sequencer.sv
// frontend_source_sequencer: source presence tracking and click-free mux sequencing (ramp down, switch, settle, ramp up).
// Define FE_SRC_AUTO_EN to compile in automatic priority source selection driven by req_auto.
module frontend_source_sequencer #(
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 256,
    parameter int RAMP_STEP     = 256
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [3:0]  src_valid,
    input  logic [1:0]  req_select,
    input  logic        req_auto,
    input  logic        req_strobe,
    output logic [1:0]  active_select,
    output logic [15:0] mute_gain,
    output logic        switching,
    output logic [3:0]  src_present,
    output logic        no_signal,
    output logic        fault
);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LT = CW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] ST = SW'(SETTLE_CYCLES - 1);
    localparam logic [15:0] STEP = 16'(RAMP_STEP);
    localparam logic [16:0] UNITY = 17'd32768;

    typedef enum logic [2:0] {SETTLE, RAMP_UP, RUN, RAMP_DOWN, SWITCH} state_t;

    state_t state, state_nxt;
    logic [3:0][CW-1:0] cnt, cnt_nxt;
    logic [3:0] present_nxt;
    logic [SW-1:0] settle_cnt, settle_nxt;
    logic [15:0] gain_nxt;
    logic [16:0] gain_up;
    logic [1:0] target, target_nxt, active_nxt;
    logic no_signal_nxt, fault_set, active_ok;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = src_valid[i] ? '0 : cnt[i] == LT ? LT : cnt[i] + CW'(1);
            present_nxt[i] = cnt_nxt[i] < LT;
        end
    end

`ifdef FE_SRC_AUTO_EN
    logic auto_mode, auto_eff;
    logic [1:0] prio;
    assign auto_eff = req_strobe ? req_auto : auto_mode;
    assign prio = src_present[3] ? 2'd3 : src_present[2] ? 2'd2 : src_present[1] ? 2'd1 : 2'd0;
    // With nothing present the auto target keeps its last value
    assign target_nxt = (auto_eff && |src_present) ? prio : req_strobe ? req_select : target;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) auto_mode <= 1'b0;
        else if (req_strobe) auto_mode <= req_auto;
    end
`else
    logic unused_auto;
    assign unused_auto = req_auto;
    assign target_nxt = req_strobe ? req_select : target;
`endif

    assign active_ok = src_present[active_select];
    assign gain_up = {1'b0, mute_gain} + {1'b0, STEP};
    assign switching = state != RUN;

    always_comb begin
        state_nxt = state;
        gain_nxt = mute_gain;
        settle_nxt = settle_cnt;
        active_nxt = active_select;
        no_signal_nxt = 1'b0;
        fault_set = 1'b0;
        case (state)
            SETTLE: begin
                gain_nxt = '0;
                if (settle_cnt != ST) settle_nxt = settle_cnt + SW'(1);
                else if (target != active_select) state_nxt = SWITCH;
                else if (active_ok) state_nxt = RAMP_UP;
                else no_signal_nxt = 1'b1;
            end
            RAMP_UP: begin
                // An abort leaves the gain where it is; the down ramp starts from it
                if (target != active_select || !active_ok) begin
                    state_nxt = RAMP_DOWN;
                    fault_set = !active_ok;
                end else begin
                    gain_nxt = gain_up >= UNITY ? UNITY[15:0] : gain_up[15:0];
                    state_nxt = gain_up >= UNITY ? RUN : RAMP_UP;
                end
            end
            RUN: begin
                gain_nxt = UNITY[15:0];
                state_nxt = (!active_ok || target != active_select) ? RAMP_DOWN : RUN;
                fault_set = !active_ok;
            end
            RAMP_DOWN: begin
                gain_nxt = mute_gain >= STEP ? mute_gain - STEP : '0;
                state_nxt = mute_gain == '0 ? SWITCH : RAMP_DOWN;
            end
            SWITCH: begin
                gain_nxt = '0;
                active_nxt = target;
                settle_nxt = '0;
                state_nxt = SETTLE;
            end
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            cnt <= {4{LT}};
            src_present <= '0;
            settle_cnt <= '0;
            mute_gain <= '0;
            active_select <= '0;
            target <= '0;
            no_signal <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            src_present <= present_nxt;
            settle_cnt <= settle_nxt;
            mute_gain <= gain_nxt;
            active_select <= active_nxt;
            target <= target_nxt;
            no_signal <= no_signal_nxt;
            fault <= fault_set | (fault & ~req_strobe);
        end
    end
endmodule

// File: tb/tb_frontend_source_sequencer.sv
// tb_frontend_source_sequencer: directed checks of presence, manual/auto switching, abort, loss and async reset.
module tb_frontend_source_sequencer;
    logic clk_sys = 1'b0;
    logic rst_n;
    logic [3:0] src_valid, src_en;
    logic [1:0] req_select;
    logic req_auto, req_strobe;
    logic [1:0] active_select;
    logic [15:0] mute_gain;
    logic switching, no_signal, fault;
    logic [3:0] src_present;
    int checks = 0;
    int errors = 0;
    int ph = 0;

    frontend_source_sequencer #(
        .LOCK_TIMEOUT(16),
        .SETTLE_CYCLES(4),
        .RAMP_STEP(8192)
    ) dut (
        .clk_sys(clk_sys),
        .rst_n(rst_n),
        .src_valid(src_valid),
        .req_select(req_select),
        .req_auto(req_auto),
        .req_strobe(req_strobe),
        .active_select(active_select),
        .mute_gain(mute_gain),
        .switching(switching),
        .src_present(src_present),
        .no_signal(no_signal),
        .fault(fault)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Enabled sources strobe once every 8 cycles
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
            ph++;
            src_valid = (ph % 8 == 0) ? src_en : 4'b0;
        end
    endtask

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0: return 32'(mute_gain);
            1: return 32'(active_select);
            2: return 32'(switching);
            default: return 32'(src_present);
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic [31:0] val, input int budget);
        int n = 0;
        while (probe(sel) != val && n < budget) begin
            step(1);
            n++;
        end
        check(tag, probe(sel), val);
    endtask

    task automatic strobe(input logic [1:0] sel, input logic auto);
        req_select = sel;
        req_auto = auto;
        req_strobe = 1'b1;
        step(1);
        req_strobe = 1'b0;
    endtask

    initial begin
        logic [15:0] down [4] = '{16'd24576, 16'd16384, 16'd8192, 16'd0};
        rst_n = 1'b0;
        src_en = 4'b0;
        src_valid = 4'b0;
        req_select = 2'd0;
        req_auto = 1'b0;
        req_strobe = 1'b0;
        step(2);
        check("rst_active", 32'(active_select), 0);
        check("rst_gain", 32'(mute_gain), 0);
        check("rst_switching", 32'(switching), 1);
        check("rst_present", 32'(src_present), 0);
        check("rst_no_signal", 32'(no_signal), 0);
        check("rst_fault", 32'(fault), 0);
        rst_n = 1'b1;
        step(6);
        check("idle_no_signal", 32'(no_signal), 1);
        check("idle_gain", 32'(mute_gain), 0);
        src_en = 4'b0001;
        wait_for("cd_present", 3, 32'h1, 20);
        wait_for("cd_ramp1", 0, 8192, 10);
        check("cd_no_signal_clr", 32'(no_signal), 0);
        step(1);
        check("cd_ramp2", 32'(mute_gain), 16384);
        step(1);
        check("cd_ramp3", 32'(mute_gain), 24576);
        step(1);
        check("cd_unity", 32'(mute_gain), 32768);
        check("cd_run", 32'(switching), 0);
        check("cd_active", 32'(active_select), 0);

        src_en = 4'b0101;
        wait_for("spdif_present", 3, 32'h5, 20);
        strobe(2'd2, 1'b0);
        check("man_k_gain", 32'(mute_gain), 32768);
        check("man_k_run", 32'(switching), 0);
        step(1);
        check("man_down_state", 32'(switching), 1);
        check("man_down_hold", 32'(mute_gain), 32768);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("man_down", 32'(mute_gain), 32'(down[i]));
        end
        check("man_active_hold", 32'(active_select), 0);
        step(1);
        check("man_sw_active", 32'(active_select), 0);
        step(1);
        check("man_new_active", 32'(active_select), 2);
        check("man_new_gain", 32'(mute_gain), 0);
        step(4);
        check("man_settle", 32'(mute_gain), 0);
        step(1);
        check("man_up1", 32'(mute_gain), 8192);
        step(3);
        check("man_unity", 32'(mute_gain), 32768);
        check("man_run", 32'(switching), 0);

        src_en = 4'b0001;
        wait_for("loss_present", 3, 32'h1, 40);
        check("loss_pre_fault", 32'(fault), 0);
        check("loss_pre_run", 32'(switching), 0);
        step(1);
        check("loss_fault", 32'(fault), 1);
        check("loss_down_hold", 32'(mute_gain), 32768);
        step(4);
        check("loss_gain0", 32'(mute_gain), 0);
        step(6);
        check("loss_active", 32'(active_select), 2);
        check("loss_no_signal", 32'(no_signal), 1);

        strobe(2'd0, 1'b0);
        check("fault_clr", 32'(fault), 0);
        check("held_no_signal", 32'(no_signal), 1);
        step(1);
        check("resw_no_signal", 32'(no_signal), 0);
        step(1);
        check("resw_active", 32'(active_select), 0);
        step(5);
        check("abort_up1", 32'(mute_gain), 8192);
        strobe(2'd1, 1'b0);
        check("abort_up2", 32'(mute_gain), 16384);
        step(1);
        check("abort_hold", 32'(mute_gain), 16384);
        step(1);
        check("abort_down1", 32'(mute_gain), 8192);
        step(1);
        check("abort_down0", 32'(mute_gain), 0);
        step(2);
        check("abort_active", 32'(active_select), 1);
        check("abort_fault", 32'(fault), 0);
        step(4);
        check("i2s_absent_no_signal", 32'(no_signal), 1);

        src_en = 4'b1011;
        wait_for("i2s_usb_present", 3, 32'hb, 20);
`ifdef FE_SRC_AUTO_EN
        strobe(2'd0, 1'b1);
        wait_for("auto_usb", 1, 3, 10);
        wait_for("auto_usb_unity", 0, 32768, 20);
        check("auto_usb_run", 32'(switching), 0);
        src_en = 4'b0011;
        wait_for("usb_gone", 3, 32'h3, 40);
        wait_for("auto_fallback", 1, 1, 40);
        check("auto_fault", 32'(fault), 1);
        wait_for("fallback_unity", 0, 32768, 40);
        check("fallback_run", 32'(switching), 0);
`else
        strobe(2'd1, 1'b1);
        wait_for("noauto_unity", 0, 32768, 30);
        step(20);
        check("noauto_active", 32'(active_select), 1);
        check("noauto_run", 32'(switching), 0);
`endif

        strobe(2'd0, 1'b0);
        step(3);
        check("pre_rst_gain", 32'(mute_gain), 16384);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gain", 32'(mute_gain), 0);
        check("arst_active", 32'(active_select), 0);
        check("arst_switching", 32'(switching), 1);
        check("arst_present", 32'(src_present), 0);
        check("arst_fault", 32'(fault), 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
